// File: rtl/easyaxi_wr_arb.sv
// N:1 AXI write-path arbiter: round-robin grant per burst over AW+W.
// W beats are counted against the captured AWLEN; WLAST mismatches are flagged.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no owner; pick next requester after rr_ptr
// AW    | owner selected, forwarding its AW channel
// W     | AW accepted, forwarding W beats until counted last beat
module easyaxi_wr_arb #(
    parameter int  MST_NUM = 4,
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    parameter int  ID_W    = 4,
    localparam int IDX_W   = $clog2(MST_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MST_NUM-1:0]        m_awvalid,
    output logic [MST_NUM-1:0]        m_awready,
    input  logic [MST_NUM*ADDR_W-1:0] m_awaddr,
    input  logic [MST_NUM*8-1:0]      m_awlen,
    input  logic [MST_NUM*ID_W-1:0]   m_awid,
    input  logic [MST_NUM-1:0]        m_wvalid,
    output logic [MST_NUM-1:0]        m_wready,
    input  logic [MST_NUM*DATA_W-1:0] m_wdata,
    input  logic [MST_NUM-1:0]        m_wlast,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [ADDR_W-1:0]         s_awaddr,
    output logic [7:0]                s_awlen,
    output logic [ID_W-1:0]           s_awid,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic [DATA_W-1:0]         s_wdata,
    output logic                      s_wlast,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      grant_vld,
    output logic                      wlast_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             grant_vld_q, grant_vld_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [7:0]       len_q, len_d;
    logic             wlast_err_q, wlast_err_d;

    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] cand;
    logic             arb_found;
    logic             aw_hs;
    logic             w_hs;
    logic             last_beat;

    // Scan from the slot after the previous owner so it has lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        cand      = '0;
        for (int off = 1; off <= MST_NUM; off++) begin
            cand = IDX_W'((int'(rr_ptr_q) + off) % MST_NUM);
            if (!arb_found && m_awvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        grant_vld_d = grant_vld_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        wlast_err_d = 1'b0;

        m_awready = '0;
        m_wready  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_awaddr  = m_awaddr[grant_idx_q*ADDR_W +: ADDR_W];
        s_awlen   = m_awlen[grant_idx_q*8 +: 8];
        s_awid    = m_awid[grant_idx_q*ID_W +: ID_W];
        s_wdata   = m_wdata[grant_idx_q*DATA_W +: DATA_W];
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        last_beat = (beat_cnt_q == len_q);

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_idx_d = arb_idx;
                    grant_vld_d = 1'b1;
                    state_d     = S_AW;
                end
            end
            S_AW: begin
                s_awvalid              = m_awvalid[grant_idx_q];
                m_awready[grant_idx_q] = s_awready;
                aw_hs                  = m_awvalid[grant_idx_q] & s_awready;
                if (aw_hs) begin
                    len_d      = s_awlen;
                    beat_cnt_d = 8'd0;
                    rr_ptr_d   = grant_idx_q;
                    state_d    = S_W;
                end
            end
            S_W: begin
                s_wvalid              = m_wvalid[grant_idx_q];
                m_wready[grant_idx_q] = s_wready;
                s_wlast               = last_beat;
                w_hs                  = m_wvalid[grant_idx_q] & s_wready;
                if (w_hs) begin
                    // The counted length decides the end; master WLAST is only audited.
                    wlast_err_d = (m_wlast[grant_idx_q] != last_beat);
                    if (last_beat) begin
                        grant_vld_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                grant_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= IDX_W'(MST_NUM - 1);
            grant_vld_q <= 1'b0;
            beat_cnt_q  <= 8'd0;
            len_q       <= 8'd0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_vld_q <= grant_vld_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign grant_vld = grant_vld_q;
    assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_easyaxi_wr_arb.sv
// Scoreboard bench for easyaxi_wr_arb: master drivers queue expected AW/W traffic,
// a negedge monitor tracks ownership at burst level and checks every slave/master output.
module tb_easyaxi_wr_arb;

    localparam int MST_NUM = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int IDX_W   = 2;
    localparam int TMO     = 300;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [MST_NUM-1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [MST_NUM*ADDR_W-1:0] m_awaddr;
    logic [MST_NUM*8-1:0]      m_awlen;
    logic [MST_NUM*ID_W-1:0]   m_awid;
    logic [MST_NUM*DATA_W-1:0] m_wdata;
    logic                      s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [ADDR_W-1:0]         s_awaddr;
    logic [7:0]                s_awlen;
    logic [ID_W-1:0]           s_awid;
    logic [DATA_W-1:0]         s_wdata;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_vld, wlast_err;

    logic              awvalid_a[MST_NUM], wvalid_a[MST_NUM], wlast_a[MST_NUM];
    logic [ADDR_W-1:0] awaddr_a[MST_NUM];
    logic [7:0]        awlen_a[MST_NUM];
    logic [ID_W-1:0]   awid_a[MST_NUM];
    logic [DATA_W-1:0] wdata_a[MST_NUM];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < MST_NUM; k++) begin
            m_awvalid[k]                   = awvalid_a[k];
            m_wvalid[k]                    = wvalid_a[k];
            m_wlast[k]                     = wlast_a[k];
            m_awaddr[k*ADDR_W +: ADDR_W]   = awaddr_a[k];
            m_awlen[k*8 +: 8]              = awlen_a[k];
            m_awid[k*ID_W +: ID_W]         = awid_a[k];
            m_wdata[k*DATA_W +: DATA_W]    = wdata_a[k];
        end
    end

    easyaxi_wr_arb #(.MST_NUM(MST_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .grant_idx(grant_idx), .grant_vld(grant_vld), .wlast_err(wlast_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [ID_W-1:0]   id;
    } aw_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              wl;
        logic              is_last;
    } w_t;

    aw_t aw_q[MST_NUM][$];
    w_t  w_q[MST_NUM][$];
    int  glog[$];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b1;
    int  slave_mode = 0;
    int  ph = 0;                 // 0 idle, 1 address phase, 2 data phase
    int  owner = 0;
    int  last_own = MST_NUM - 1;
    bit  err_q = 1'b0;
    int  whs_cnt = 0;
    int  dut_err_cnt = 0;
    aw_t mon_a;
    w_t  mon_w;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Winner is the requester closest after the previous owner, going upward with wrap.
    function automatic int rr_pick(input int lst, input logic [MST_NUM-1:0] req);
        int best, bd, d;
        best = -1;
        bd   = MST_NUM;
        for (int c = 0; c < MST_NUM; c++) begin
            d = (c - lst - 1 + 2 * MST_NUM) % MST_NUM;
            if (req[c] && d < bd) begin
                bd   = d;
                best = c;
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        #1;
        case (slave_mode)
            1: begin
                s_awready = ($urandom_range(0, 3) != 0);
                s_wready  = ($urandom_range(0, 3) != 0);
            end
            2: begin
                s_awready = 1'b1;
                s_wready  = ~s_wready;
            end
            default: begin
                s_awready = 1'b1;
                s_wready  = 1'b1;
            end
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            if (mon_en) begin
                chk("rst_grant_vld", grant_vld, 0);
                chk("rst_grant_idx", grant_idx, 0);
                chk("rst_m_awready", m_awready, 0);
                chk("rst_m_wready", m_wready, 0);
                chk("rst_s_awvalid", s_awvalid, 0);
                chk("rst_s_wvalid", s_wvalid, 0);
                chk("rst_wlast_err", wlast_err, 0);
            end
            ph       = 0;
            last_own = MST_NUM - 1;
            err_q    = 1'b0;
        end else if (mon_en) begin
            if (wlast_err) dut_err_cnt++;
            chk("grant_vld", grant_vld, (ph != 0));
            if (ph != 0) chk("grant_idx", grant_idx, owner);
            chk("m_awready", m_awready, (ph == 1 && s_awready) ? (64'd1 << owner) : 64'd0);
            chk("m_wready", m_wready, (ph == 2 && s_wready) ? (64'd1 << owner) : 64'd0);
            chk("s_awvalid", s_awvalid, (ph == 1) && m_awvalid[owner]);
            chk("s_wvalid", s_wvalid, (ph == 2) && m_wvalid[owner]);
            chk("wlast_err", wlast_err, err_q);
            err_q = 1'b0;
            case (ph)
                0: if (|m_awvalid) begin
                    owner = rr_pick(last_own, m_awvalid);
                    glog.push_back(owner);
                    ph = 1;
                end
                1: if (m_awvalid[owner] && s_awready) begin
                    if (aw_q[owner].size() == 0) begin
                        chk("aw_q_underflow", 1, 0);
                    end else begin
                        mon_a = aw_q[owner].pop_front();
                        chk("s_awaddr", s_awaddr, mon_a.addr);
                        chk("s_awlen", s_awlen, mon_a.len);
                        chk("s_awid", s_awid, mon_a.id);
                    end
                    last_own = owner;
                    ph = 2;
                end
                default: if (m_wvalid[owner] && s_wready) begin
                    whs_cnt++;
                    if (w_q[owner].size() == 0) begin
                        chk("w_q_underflow", 1, 0);
                        ph = 0;
                    end else begin
                        mon_w = w_q[owner].pop_front();
                        chk("s_wdata", s_wdata, mon_w.data);
                        chk("s_wlast", s_wlast, mon_w.is_last);
                        err_q = (mon_w.wl != mon_w.is_last);
                        if (mon_w.is_last) ph = 0;
                    end
                end
            endcase
        end
    end

    // Handshake happens at the posedge following a negedge that shows ready.
    task automatic wait_rdy(input int k, input bit isw);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(isw ? m_wready[k] : m_awready[k]) && t < TMO);
        if (!(isw ? m_wready[k] : m_awready[k])) begin
            checks++;
            errors++;
            $display("FAIL timeout master=%0d wchan=%0d actual=not_ready required=ready", k, isw);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input int nb, input bit rnd, input int flen, input logic [7:0] flip);
        for (int n = 0; n < nb; n++) begin
            int         len;
            logic [7:0] fl;
            aw_t        a;
            w_t         bl[8];
            bit         early;
            if (n == 0) begin @(posedge clk); #1; end
            if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            len = rnd ? (($urandom_range(0, 7) == 0) ? 7 : int'($urandom_range(0, 3))) : flen;
            fl  = rnd ? (($urandom_range(0, 3) == 0) ? (8'd1 << $urandom_range(0, len)) : 8'd0) : flip;
            a.addr = $urandom;
            a.len  = 8'(len);
            a.id   = ID_W'($urandom);
            aw_q[k].push_back(a);
            for (int b = 0; b <= len; b++) begin
                bl[b].data    = $urandom;
                bl[b].is_last = (b == len);
                bl[b].wl      = bl[b].is_last ^ fl[b];
                w_q[k].push_back(bl[b]);
            end
            awvalid_a[k] = 1'b1;
            awaddr_a[k]  = a.addr;
            awlen_a[k]   = a.len;
            awid_a[k]    = a.id;
            early = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            if (early) begin
                wvalid_a[k] = 1'b1;
                wdata_a[k]  = bl[0].data;
                wlast_a[k]  = bl[0].wl;
            end
            wait_rdy(k, 1'b0);
            awvalid_a[k] = 1'b0;
            for (int b = 0; b <= len; b++) begin
                if (rnd && b > 0 && $urandom_range(0, 3) == 0) begin
                    wvalid_a[k] = 1'b0;
                    @(posedge clk); #1;
                end
                wvalid_a[k] = 1'b1;
                wdata_a[k]  = bl[b].data;
                wlast_a[k]  = bl[b].wl;
                wait_rdy(k, 1'b1);
            end
            wvalid_a[k] = 1'b0;
            wlast_a[k]  = 1'b0;
        end
    endtask

    task automatic chk_glog(input string nm, input int exp[$]);
        chk({nm, "_len"}, glog.size(), exp.size());
        if (glog.size() == exp.size())
            for (int i = 0; i < exp.size(); i++) chk(nm, glog[i], exp[i]);
        glog.delete();
    endtask

    initial begin
        int e0;
        int exp_a[$];
        rst_n = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        for (int k = 0; k < MST_NUM; k++) begin
            awvalid_a[k] = 1'b0; wvalid_a[k] = 1'b0; wlast_a[k] = 1'b0;
            awaddr_a[k]  = '0;   awlen_a[k]  = '0;   awid_a[k]  = '0;  wdata_a[k] = '0;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // all four request continuously with len 0
        slave_mode = 0;
        glog.delete();
        fork
            drv(0, 2, 1'b0, 0, 8'h0);
            drv(1, 2, 1'b0, 0, 8'h0);
            drv(2, 2, 1'b0, 0, 8'h0);
            drv(3, 2, 1'b0, 0, 8'h0);
        join
        exp_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_glog("rotation", exp_a);

        // random traffic with random slave back-pressure
        slave_mode = 1;
        fork
            drv(0, 25, 1'b1, 0, 8'h0);
            drv(1, 25, 1'b1, 0, 8'h0);
            drv(2, 25, 1'b1, 0, 8'h0);
            drv(3, 25, 1'b1, 0, 8'h0);
        join
        glog.delete();

        // priority after owner 1
        slave_mode = 0;
        drv(1, 1, 1'b0, 0, 8'h0);
        fork
            drv(0, 1, 1'b0, 0, 8'h0);
            drv(1, 1, 1'b0, 0, 8'h0);
        join
        drv(1, 1, 1'b0, 0, 8'h0);
        fork
            drv(0, 1, 1'b0, 0, 8'h0);
            drv(1, 1, 1'b0, 0, 8'h0);
            drv(2, 1, 1'b0, 0, 8'h0);
        join
        exp_a = '{1, 0, 1, 1, 2, 0, 1};
        chk_glog("after_owner1", exp_a);

        // len 3 with toggling wready
        slave_mode = 2;
        e0 = whs_cnt;
        drv(2, 1, 1'b0, 3, 8'h0);
        chk("m2_beats", whs_cnt - e0, 4);

        // early wlast on beat 2 of 4
        slave_mode = 0;
        e0 = dut_err_cnt;
        drv(1, 1, 1'b0, 3, 8'b0000_0010);
        repeat (3) @(negedge clk);
        chk("m1_err_pulses", dut_err_cnt - e0, 1);

        // master 3 holds W early while master 0 is in its data phase
        fork
            drv(0, 1, 1'b0, 3, 8'h0);
            begin repeat (3) @(posedge clk); #1; drv(3, 1, 1'b0, 0, 8'h0); end
        join
        glog.delete();

        // reset in the middle of a burst
        mon_en = 1'b0;
        @(posedge clk); #1;
        awvalid_a[2] = 1'b1;
        awlen_a[2]   = 8'd3;
        wait_rdy(2, 1'b0);
        awvalid_a[2] = 1'b0;
        wvalid_a[2]  = 1'b1;
        wait_rdy(2, 1'b1);
        wait_rdy(2, 1'b1);
        @(negedge clk);
        chk("pre_rst_wvalid", s_wvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wvalid", s_wvalid, 0);
        chk("rst_mid_wready", m_wready, 0);
        chk("rst_mid_grant_vld", grant_vld, 0);
        wvalid_a[2] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_grant_vld", grant_vld, 0);
        glog.delete();
        fork
            drv(1, 1, 1'b0, 0, 8'h0);
            drv(0, 1, 1'b0, 0, 8'h0);
        join
        exp_a = '{0, 1};
        chk_glog("post_rst_prio", exp_a);

        repeat (3) @(negedge clk);
        for (int k = 0; k < MST_NUM; k++) begin
            chk("aw_q_left", aw_q[k].size(), 0);
            chk("w_q_left", w_q[k].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/easyaxi_wr_arb.md
Name: easyaxi_wr_arb

Overview:
N:1 write-path arbiter. It shares one downstream AXI slave write port (AW + W) between MST_NUM upstream masters.
- Masters are selected round-robin.
- A grant is held from AW handshake until the last W beat of that burst.
- W beats are counted against the captured AWLEN, and a protocol-error pulse is raised on a WLAST mismatch.
- Sits between master ports and the slave port. An external B router uses grant_idx and grant_vld to steer responses.

Parameters:
MST_NUM, 4, number of upstream masters (≥2)
ADDR_W, 32, address width
DATA_W, 32, write data width
ID_W, 4, AWID width
IDX_W, $clog2(MST_NUM), master index width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m_awvalid  in  MST_NUM  per-master AW valid
m_awready  out  MST_NUM  per-master AW ready
m_awaddr  in  MST_NUM*ADDR_W  packed; master k at [k*ADDR_W +: ADDR_W]
m_awlen  in  MST_NUM*8  packed burst length − 1
m_awid  in  MST_NUM*ID_W  packed ID
m_wvalid  in  MST_NUM  per-master W valid
m_wready  out  MST_NUM  per-master W ready
m_wdata  in  MST_NUM*DATA_W  packed write data
m_wlast  in  MST_NUM  per-master WLAST
s_awvalid / s_awready  out / in  1  slave AW handshake
s_awaddr  out  ADDR_W  granted address
s_awlen  out  8  granted length
s_awid  out  ID_W  granted ID
s_wvalid / s_wready  out / in  1  slave W handshake
s_wdata  out  DATA_W  granted data
s_wlast  out  1  generated last (beat_cnt == len_q)
grant_idx  out  IDX_W  index of current owner
grant_vld  out  1  high from AW state entry through final W beat
wlast_err  out  1  one-cycle pulse on WLAST mismatch

Behaviour:
- Reset (async, rst_n low): state=IDLE, grant_idx=0, grant_vld=0, rr_ptr=MST_NUM−1 (so master 0 has first priority), beat_cnt=0, len_q=0, wlast_err=0.
  - All m_*ready and s_*valid are 0 while in IDLE/reset.
  - Asserting reset mid-burst abandons the burst with no completion. The slave sees valid drop immediately.
- FSM states: IDLE, AW, W.
- IDLE:
  - If any m_awvalid is set, choose the first requester scanning from rr_ptr+1 upward with wrap-around.
  - Register the winner into grant_idx and set grant_vld=1. Go to AW next cycle (1-cycle arbitration latency).
  - Arbitration is evaluated only in IDLE. Requests arriving later wait.
- AW:
  - s_awvalid = m_awvalid[grant_idx]. s_awaddr, s_awlen and s_awid are muxed from grant_idx.
  - m_awready[grant_idx] = s_awready. All other m_awready are 0.
  - On handshake: len_q ← awlen, beat_cnt ← 0, rr_ptr ← grant_idx, go to W.
  - If the granted master drops awvalid before handshake (illegal), the FSM stays in AW.
- W:
  - s_wvalid = m_wvalid[grant_idx]. s_wdata is muxed. m_wready[grant_idx] = s_wready. Other masters' wready are 0.
  - s_wlast = (beat_cnt == len_q).
  - On each beat handshake, beat_cnt increments (8-bit, no wrap since its maximum is len_q).
  - On the handshake with beat_cnt == len_q: go to IDLE and clear grant_vld. One idle bubble is required before the next arbitration.
  - wlast_err pulses for one cycle on any beat handshake where m_wlast[grant_idx] != s_wlast.
  - The burst still completes on the counted length. A master's early WLAST does not end the burst.
- W data arriving before AW is not accepted. wready stays 0 until state W.
- Simultaneous requests: strict rotation. The last owner has lowest priority next round.
- A single requester is re-granted back-to-back with one IDLE cycle between bursts.
- Widths: muxes are driven combinationally from the registered grant_idx. There are no combinational paths from m_awvalid to grant_idx.

Test Plan:
- Reset → all readies/valids 0, grant_vld=0, grant_idx=0. Assert rst_n low mid-W beat 2 of 4 → s_wvalid=0 the same cycle, state IDLE after release.
- Masters 0–3 all request AW (len=0) continuously → grants in order 0,1,2,3,0. Each burst takes 3 cycles minimum (arb, AW, W).
- Master 2 awlen=3, s_wready toggling 1,0,1 → exactly 4 W handshakes. s_wlast high only on the 4th. grant_vld drops the cycle after.
- Master 1 asserts wlast on beat 2 of awlen=3 → wlast_err pulses once, burst continues to 4 beats, no further error on beat 4 if wlast is asserted.
- Master 3 holds wvalid before its AW is granted while master 0 is in W → m_wready[3]=0 throughout. Master 0's data is unaffected.
- After a grant to master 1, masters 0 and 1 both request → master 0 is skipped only if master 2 or 3 is requesting. Otherwise master 0 wins before master 1.
